dmem_access_unit: RTL and testbench

Data-memory access sequencer sitting between the multicycle control FSM/datapath and the data memory. On a one-cycle start pulse it turns a load or store request (address, store data, funct3 size code) into a byte-lane-enabled, request/acknowledge transaction on a doubleword-wide memory port. Load data is returned sign- or zero-extended, and completion is signalled by a one-cycle done pulse. Misaligned and illegal accesses are rejected without touching memory.

---
 rtl/dmem_access_unit_pkg.sv | 47 ++++
 rtl/load_extender.sv | 34 +++
 rtl/dmem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// rtl/dmem_access_unit_pkg.sv - shared opcodes and operation encodings for the data-memory access unit
// Contents:
//   F3_LB..F3_LWU, F3_SB..F3_SD : funct3 size/sign codes (instruction[14:12])
//   _DM_LOAD / _DM_STORE        : DMemOp encodings driven by the control FSM
//   dma_state_e                 : dmem_access_unit sequencer states
//   size_bytes()                : funct3 -> access size in bytes (1/2/4/8)
package dmem_access_unit_pkg;

    // Load size/sign codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store size codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // DMemOp encodings
    localparam logic _DM_LOAD  = 1'b0;
    localparam logic _DM_STORE = 1'b1;

    typedef enum logic [1:0] {
        DMA_IDLE = 2'd0,
        DMA_REQ  = 2'd1,
        DMA_DONE = 2'd2
    } dma_state_e;

    // Access size in bytes; the illegal code 111 decodes as 8 and is
    // rejected separately by the legality check.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        logic [3:0] n;
        case (f3)
            F3_LB, F3_LBU: n = 4'd1;
            F3_LH, F3_LHU: n = 4'd2;
            F3_LW, F3_LWU: n = 4'd4;
            default:       n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/load_extender.sv
// rtl/load_extender.sv - selects the addressed lane of a memory doubleword and sign/zero-extends it
// Ports:
//   i_rdata  [XLEN]  raw read data from the memory bus
//   i_off    [OFFW]  byte offset of the access within the doubleword
//   i_funct3 [3]     size/sign code of the load
//   o_data   [XLEN]  right-aligned, extended load result (combinational)
module load_extender
    import dmem_access_unit_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [OFFW-1:0] i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_sh;

    always_comb begin
        w_sh = i_rdata >> {i_off, 3'b000};
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_sh[7]}},   w_sh[7:0]};
            F3_LH:   o_data = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
            F3_LW:   o_data = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
            F3_LBU:  o_data = {{(XLEN-8){1'b0}},      w_sh[7:0]};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}},     w_sh[15:0]};
            F3_LWU:  o_data = {{(XLEN-32){1'b0}},     w_sh[31:0]};
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - load/store sequencer between control FSM and a doubleword data memory
// Optional feature: define DMEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES REQ cycles without ack.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_start                 one-cycle request pulse (sampled only in IDLE)
//   i_we, i_funct3          DMemOp (0 load / 1 store), size/sign code
//   i_addr, i_wdata         byte address, right-aligned store data
//   o_rdata                 extended load result, held until the next successful load
//   o_done, o_err, o_busy   completion pulse, error qualifier, not-idle flag
//   o_mem_req, o_mem_we     memory request (held until ack), write strobe
//   o_mem_addr, o_mem_be    doubleword-aligned address, byte enables
//   o_mem_wdata             store data shifted to its lanes
//   i_mem_ack, i_mem_rdata  memory completion, read data
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [2:0]        i_funct3,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0] o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    localparam int LANES = XLEN / 8;
    localparam int OFFW  = $clog2(LANES);

    dma_state_e        r_state;
    logic [2:0]        r_funct3;
    logic [OFFW-1:0]   r_off;
    logic [XLEN-1:0]   r_rdata;
    logic              r_done;
    logic              r_err;
    logic              r_busy;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [XLEN-1:0]   r_mem_addr;
    logic [LANES-1:0]  r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata;

`ifdef DMEM_TIMEOUT_EN
    localparam int TCW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TCW     = (TCW_RAW < 8) ? 8 : TCW_RAW;
    logic [TCW-1:0]    r_tcnt;
`endif

    logic [3:0]        w_nbytes;
    logic [OFFW-1:0]   w_off;
    logic              w_legal;
    logic              w_aligned;
    logic [LANES-1:0]  w_be_mask;
    logic [LANES-1:0]  w_be;
    logic [XLEN-1:0]   w_wdata_sh;
    logic [XLEN-1:0]   w_addr_al;
    logic [XLEN-1:0]   w_load_data;

    assign w_nbytes = size_bytes(i_funct3);
    assign w_off    = i_addr[OFFW-1:0];

    // Stores only have the four size codes; loads reject only 111.
    // Accesses wider than the bus are rejected as well.
    assign w_legal = ((i_we == _DM_STORE) ? (i_funct3 <= F3_SD) : (i_funct3 != 3'b111))
                     && (int'(w_nbytes) <= LANES);
    assign w_aligned = (w_off & OFFW'(w_nbytes - 4'd1)) == '0;

    always_comb begin
        case (w_nbytes)
            4'd1:    w_be_mask = LANES'(1);
            4'd2:    w_be_mask = LANES'(3);
            4'd4:    w_be_mask = LANES'(15);
            default: w_be_mask = {LANES{1'b1}};
        endcase
    end

    assign w_be       = w_be_mask << w_off;
    assign w_wdata_sh = i_wdata << {w_off, 3'b000};
    assign w_addr_al  = {i_addr[XLEN-1:OFFW], {OFFW{1'b0}}};

    load_extender #(.XLEN(XLEN)) u_load_extender (
        .i_rdata  (i_mem_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_load_data)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= DMA_IDLE;
            r_funct3    <= '0;
            r_off       <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
`ifdef DMEM_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            case (r_state)
                DMA_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (i_start) begin
                        r_funct3 <= i_funct3;
                        r_off    <= w_off;
                        r_busy   <= 1'b1;
                        if (w_legal && w_aligned) begin
                            r_state     <= DMA_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= i_we;
                            r_mem_addr  <= w_addr_al;
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata_sh;
`ifdef DMEM_TIMEOUT_EN
                            r_tcnt      <= '0;
`endif
                        end else begin
                            // Rejected: straight to DONE, memory never sees it.
                            r_state <= DMA_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end

                DMA_REQ: begin
                    if (i_mem_ack) begin
                        r_state   <= DMA_DONE;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        if (r_mem_we == _DM_LOAD) begin
                            r_rdata <= w_load_data;
                        end
                    end
`ifdef DMEM_TIMEOUT_EN
                    // Ack is tested first so an ack on the expiry cycle wins.
                    else if (r_tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= DMA_DONE;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end

                DMA_DONE: begin
                    r_state <= DMA_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= DMA_IDLE;
                    r_done    <= 1'b0;
                    r_err     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_rdata     = r_rdata;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_busy      = r_busy;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - randomized, model-checked bench for dmem_access_unit
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [63:0] i_addr;
    logic [63:0] i_wdata;
    logic [63:0] o_rdata;
    logic        o_done;
    logic        o_err;
    logic        o_busy;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [7:0]  o_mem_be;
    logic [63:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [63:0] i_mem_rdata;

    dmem_access_unit #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_rdata     (o_rdata),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_busy      (o_busy),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_be    (o_mem_be),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle
    logic        exp_busy, exp_req, exp_done, exp_err, exp_we;
    logic [63:0] exp_rdata, exp_addr, exp_wd;
    logic [7:0]  exp_be;
    logic [63:0] m_rdata;

    // Observations for literal pins
    logic [7:0]  seen_be;
    logic [63:0] seen_wd;
    logic        seen_we;
    int          req_cnt = 0;
    int          done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, wanted %h at %0t", nm, act, exp, $time);
        end
    endtask

    // The single per-cycle compare point: sample mid-cycle, then move to just after the next edge.
    task automatic tick();
        @(negedge i_clk);
        chk("busy", 64'(o_busy), 64'(exp_busy));
        chk("mem_req", 64'(o_mem_req), 64'(exp_req));
        chk("done", 64'(o_done), 64'(exp_done));
        chk("err", 64'(o_err), 64'(exp_err));
        chk("rdata", o_rdata, exp_rdata);
        if (exp_req) begin
            chk("mem_addr", o_mem_addr, exp_addr);
            chk("mem_be", 64'(o_mem_be), 64'(exp_be));
            chk("mem_we", 64'(o_mem_we), 64'(exp_we));
            chk("mem_wdata", o_mem_wdata, exp_wd);
            seen_be = o_mem_be;
            seen_wd = o_mem_wdata;
            seen_we = o_mem_we;
        end
        if (o_mem_req) req_cnt++;
        if (o_done) done_cnt++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_idle();
        exp_busy = 1'b0; exp_req = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    endtask

    // Byte-wise view of a load: gather n bytes starting at the offset, then extend.
    function automatic logic [63:0] model_load(input logic [2:0] f3, input int off, input logic [63:0] mrd);
        int n;
        logic [63:0] v;
        n = 1 << f3[1:0];
        v = '0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = mrd[8*(off+j) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, input logic [63:0] mrd,
                           input int delay, input bit poke);
        int  n, off, reqc;
        bit  ok, to;
        n   = 1 << f3[1:0];
        off = int'(addr % 64'd8);
        ok  = (we ? (f3 < 3'd4) : (f3 != 3'd7)) && ((addr % 64'(n)) == 0);
        to  = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        to  = (delay >= TO);
`endif
        reqc = to ? TO : delay + 1;

        // Cycle 0: start sampled in IDLE
        i_start = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
        i_mem_ack = 1'b0; i_mem_rdata = {$urandom, $urandom};
        set_idle();
        tick();

        // Request inputs change afterwards; the unit must have latched them.
        i_start = 1'b0; i_addr = {$urandom, $urandom}; i_wdata = {$urandom, $urandom};
        i_funct3 = 3'($urandom_range(0, 7)); i_we = 1'($urandom_range(0, 1));
        if (!ok) begin
            exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b1; exp_err = 1'b1;
            i_start = poke;
            tick();
        end else begin
            exp_addr = addr & ~64'd7;
            exp_we   = we;
            exp_wd   = wd << (8 * off);
            for (int i = 0; i < 8; i++) exp_be[i] = (i >= off) && (i < off + n);
            for (int c = 0; c < reqc; c++) begin
                exp_busy = 1'b1; exp_req = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
                i_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                i_mem_ack = (!to && c == delay);
                i_mem_rdata = i_mem_ack ? mrd : {$urandom, $urandom};
                tick();
            end
            i_mem_ack = 1'b0; i_mem_rdata = {$urandom, $urandom};
            i_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b1; exp_err = to;
            if (!to && !we) m_rdata = model_load(f3, off, mrd);
            exp_rdata = m_rdata;
            tick();
        end

        // Back in IDLE; a stray ack here must do nothing.
        i_start = 1'b0;
        i_mem_ack = 1'($urandom_range(0, 1));
        set_idle();
        tick();
        i_mem_ack = 1'b0;
    endtask

    task automatic run_random(input int count);
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          n;
        for (int k = 0; k < count; k++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            n    = 1 << f3[1:0];
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(n - 1);
            run_txn(we, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
        $fatal(1);
    end

    initial begin
        int base_req, base_done;
        i_reset = 1'b1; i_start = 1'b0; i_we = 1'b0; i_funct3 = 3'd0;
        i_addr = '0; i_wdata = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
        m_rdata = '0; exp_rdata = '0; set_idle();
        exp_addr = '0; exp_wd = '0; exp_be = '0; exp_we = 1'b0;
        seen_be = '0; seen_wd = '0; seen_we = 1'b0;

        #3;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_mem_req", 64'(o_mem_req), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_rdata", o_rdata, 64'd0);
        chk("rst_mem_be", 64'(o_mem_be), 64'd0);
        chk("rst_mem_we", 64'(o_mem_we), 64'd0);
        chk("rst_mem_addr", o_mem_addr, 64'd0);
        chk("rst_mem_wdata", o_mem_wdata, 64'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        tick();

        // ld, ack in the first REQ cycle
        run_txn(1'b0, 3'b011, 64'h10, 64'h0, 64'h1122334455667788, 0, 1'b0);
        chk("pin_ld_be", 64'(seen_be), 64'hFF);
        chk("pin_ld_rdata", o_rdata, 64'h1122334455667788);

        // lb / lbu of byte 3 = 0x80
        run_txn(1'b0, 3'b000, 64'h13, 64'h0, 64'h0000000080000000, 1, 1'b0);
        chk("pin_lb_be", 64'(seen_be), 64'h08);
        chk("pin_lb_rdata", o_rdata, 64'hFFFFFFFFFFFFFF80);
        run_txn(1'b0, 3'b100, 64'h13, 64'h0, 64'h0000000080000000, 2, 1'b0);
        chk("pin_lbu_be", 64'(seen_be), 64'h08);
        chk("pin_lbu_rdata", o_rdata, 64'h80);

        // sh at offset 6
        run_txn(1'b1, 3'b001, 64'h06, 64'hBEEF, 64'hDEADDEADDEADDEAD, 0, 1'b0);
        chk("pin_sh_be", 64'(seen_be), 64'hC0);
        chk("pin_sh_wdata", seen_wd, 64'hBEEF000000000000);
        chk("pin_sh_we", 64'(seen_we), 64'd1);
        chk("pin_sh_rdata", o_rdata, 64'h80);

        // Rejected: misaligned lw, illegal load code 111
        base_req = req_cnt;
        run_txn(1'b0, 3'b010, 64'h0A, 64'h0, 64'h0, 0, 1'b0);
        run_txn(1'b0, 3'b111, 64'h20, 64'h0, 64'h0, 0, 1'b0);
        chk("pin_reject_no_req", 64'(req_cnt - base_req), 64'd0);
        chk("pin_reject_rdata", o_rdata, 64'h80);

        // Delayed ack with start pulsed during REQ
        base_req = req_cnt; base_done = done_cnt;
        i_start = 1'b0;
        run_txn(1'b0, 3'b011, 64'h40, 64'h0, 64'hCAFEF00D12345678, 5, 1'b1);
`ifdef DMEM_TIMEOUT_EN
        chk("pin_delay_req_cycles", 64'(req_cnt - base_req), 64'(TO));
`else
        chk("pin_delay_req_cycles", 64'(req_cnt - base_req), 64'd6);
`endif
        chk("pin_delay_done_count", 64'(done_cnt - base_done), 64'd1);

`ifdef DMEM_TIMEOUT_EN
        base_req = req_cnt; base_done = done_cnt;
        run_txn(1'b0, 3'b011, 64'h48, 64'h0, 64'h0, 20, 1'b0);
        chk("pin_timeout_req_cycles", 64'(req_cnt - base_req), 64'd4);
        chk("pin_timeout_done_count", 64'(done_cnt - base_done), 64'd1);
`endif

        run_random(150);

        // Reset while in REQ: request and busy drop at once, no done follows.
        i_start = 1'b1; i_we = 1'b0; i_funct3 = 3'b011; i_addr = 64'h80; i_mem_ack = 1'b0;
        set_idle();
        tick();
        i_start = 1'b0;
        exp_busy = 1'b1; exp_req = 1'b1; exp_addr = 64'h80; exp_be = 8'hFF;
        exp_we = 1'b0; exp_wd = i_wdata;
        tick();
        #2;
        i_reset = 1'b1;
        #1;
        chk("midrst_mem_req", 64'(o_mem_req), 64'd0);
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_done", 64'(o_done), 64'd0);
        chk("midrst_rdata", o_rdata, 64'd0);
        m_rdata = '0; exp_rdata = '0;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        i_mem_ack = 1'b1;
        set_idle();
        base_done = done_cnt;
        for (int k = 0; k < 3; k++) tick();
        i_mem_ack = 1'b0;
        chk("midrst_no_done", 64'(done_cnt - base_done), 64'd0);

        run_random(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
